// File: rtl/overture_fetch_exec_if.sv
// Bus bundle between the overture sequencer and its surroundings:
// program ROM read port plus the valid/ready input and output ports.
interface overture_fetch_exec_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output rom_addr, in_ready, out_data, out_valid,
        input  rom_data, in_data, in_valid, out_ready
    );

    modport slave (
        input  rom_addr, in_ready, out_data, out_valid,
        output rom_data, in_data, in_valid, out_ready
    );
endinterface

// File: rtl/overture_fetch_exec.sv
// Overture fetch/execute sequencer: reads one ROM byte per
// instruction, runs it on six 8-bit registers and a handshaked port.
module overture_fetch_exec #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic clk,
    input  logic rst_n,
    overture_fetch_exec_if.master bus,
    output logic halted
);
    typedef enum logic [2:0] {
        FETCH, EXEC, IN_WAIT, OUT_WAIT, HALT
    } state_t;

    state_t     state, state_d;
    logic [7:0] pc, pc_d;
    logic [7:0] ir, ir_d;
    logic [7:0] rf   [6];
    logic [7:0] rf_d [6];
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       halted_q, halted_d;

    logic       wr_en;
    logic [2:0] wr_dst;
    logic [7:0] wr_val;
    logic [2:0] src, dst;
    logic [7:0] src_val, alu, pc_inc;
    logic       take, zero, neg;

    assign src    = ir[5:3];
    assign dst    = ir[2:0];
    assign pc_inc = pc + 8'd1;
    assign zero   = (rf[3] == 8'h00);
    assign neg    = rf[3][7];

    assign bus.rom_addr  = pc;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign halted        = halted_q;

    always_comb begin
        src_val = 8'h00;
        for (int i = 0; i < 6; i++)
            if (src == 3'(i)) src_val = rf[i];
    end

    // ops 6 and 7 write r3 back unchanged
    always_comb begin
        alu = rf[3];
        case (ir[2:0])
            3'd0: alu = rf[1] | rf[2];
            3'd1: alu = ~(rf[1] & rf[2]);
            3'd2: alu = ~(rf[1] | rf[2]);
            3'd3: alu = rf[1] & rf[2];
            3'd4: alu = rf[1] + rf[2];
            3'd5: alu = rf[1] - rf[2];
            default: alu = rf[3];
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (ir[2:0])
            3'd0: take = 1'b0;
            3'd1: take = zero;
            3'd2: take = neg;
            3'd3: take = neg | zero;
            3'd4: take = 1'b1;
            3'd5: take = ~zero;
            3'd6: take = ~neg;
            3'd7: take = ~neg & ~zero;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        ir_d        = ir;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        wr_en       = 1'b0;
        wr_dst      = 3'd0;
        wr_val      = 8'h00;
        unique case (state)
            FETCH: begin
                ir_d    = bus.rom_data;
                state_d = EXEC;
            end
            EXEC: begin
                unique case (ir[7:6])
                    2'b00: begin
                        wr_en   = 1'b1;
                        wr_val  = {2'b00, ir[5:0]};
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                    2'b01: begin
                        wr_en   = 1'b1;
                        wr_dst  = 3'd3;
                        wr_val  = alu;
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                    2'b10: begin
                        if (src == 3'd7 || dst == 3'd7) begin
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end else if (src == 3'd6) begin
                            in_ready_d = 1'b1;
                            state_d    = IN_WAIT;
                        end else if (dst == 3'd6) begin
                            out_data_d  = src_val;
                            out_valid_d = 1'b1;
                            state_d     = OUT_WAIT;
                        end else begin
                            wr_en   = 1'b1;
                            wr_dst  = dst;
                            wr_val  = src_val;
                            pc_d    = pc_inc;
                            state_d = FETCH;
                        end
                    end
                    2'b11: begin
                        pc_d    = take ? rf[0] : pc_inc;
                        state_d = FETCH;
                    end
                    default: ;
                endcase
            end
            IN_WAIT: begin
                if (bus.in_valid) begin
                    in_ready_d = 1'b0;
                    if (dst == 3'd6) begin
                        out_data_d  = bus.in_data;
                        out_valid_d = 1'b1;
                        state_d     = OUT_WAIT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_dst  = dst;
                        wr_val  = bus.in_data;
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                end
            end
            OUT_WAIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_inc;
                    state_d     = FETCH;
                end
            end
            HALT: ;
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 6; i++)
            rf_d[i] = (wr_en && wr_dst == 3'(i)) ? wr_val : rf[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            ir          <= 8'h00;
            rf          <= '{default: 8'h00};
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            ir          <= ir_d;
            rf          <= rf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
        end
    end
endmodule

// File: tb/tb_overture_fetch_exec.sv
// Bench for overture_fetch_exec: directed program checks plus random
// programs compared against an instruction-level reference model.
module tb_overture_fetch_exec;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       halted;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] rom [256];

    int n_chk = 0;
    int n_err = 0;

    overture_fetch_exec_if bus ();

    assign bus.rom_data  = rom[bus.rom_addr];
    assign bus.in_data   = in_data;
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;

    overture_fetch_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic give(logic [7:0] v);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            step(1);
            w++;
        end
        check("in_ready_wait", bus.in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = v;
        step(1);
        in_valid = 1'b0;
    endtask

    function automatic bit cond_holds(logic [2:0] c, logic [7:0] v);
        int s = int'($signed(v));
        case (c)
            3'd0: return 1'b0;
            3'd1: return s == 0;
            3'd2: return s < 0;
            3'd3: return s <= 0;
            3'd4: return 1'b1;
            3'd5: return s != 0;
            3'd6: return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // reference: one loop iteration per instruction, no timing
    logic [7:0] m_r [6];
    logic [7:0] m_pc;
    bit         m_halt;
    int         m_nin;
    logic [7:0] inq [512];
    logic [7:0] exp_out [$];
    logic [7:0] got_out [$];

    task automatic ref_run();
        logic [7:0] b, v;
        int s, d, a, c;
        m_pc = 8'h00;
        foreach (m_r[i]) m_r[i] = 8'h00;
        m_halt = 1'b0;
        m_nin  = 0;
        exp_out.delete();
        for (int k = 0; k < 150 && !m_halt; k++) begin
            b = rom[m_pc];
            s = int'(b[5:3]);
            d = int'(b[2:0]);
            a = int'(m_r[1]);
            c = int'(m_r[2]);
            case (b[7:6])
                2'b00: begin
                    m_r[0] = b & 8'h3F;
                    m_pc++;
                end
                2'b01: begin
                    case (d)
                        0: m_r[3] = m_r[1] | m_r[2];
                        1: m_r[3] = ~(m_r[1] & m_r[2]);
                        2: m_r[3] = ~(m_r[1] | m_r[2]);
                        3: m_r[3] = m_r[1] & m_r[2];
                        4: m_r[3] = 8'((a + c) % 256);
                        5: m_r[3] = 8'((a - c + 256) % 256);
                        default: ;
                    endcase
                    m_pc++;
                end
                2'b11: begin
                    if (cond_holds(b[2:0], m_r[3])) m_pc = m_r[0];
                    else m_pc++;
                end
                default: begin
                    if (s == 7 || d == 7) begin
                        m_halt = 1'b1;
                    end else begin
                        if (s == 6) begin
                            v = inq[m_nin];
                            m_nin++;
                        end else begin
                            v = m_r[s];
                        end
                        if (d == 6) exp_out.push_back(v);
                        else m_r[d] = v;
                        m_pc++;
                    end
                end
            endcase
        end
    endtask

    task automatic random_prog();
        int in_idx = 0;
        int tries = 0;
        int n;
        do begin
            foreach (rom[i]) rom[i] = 8'($urandom);
            foreach (inq[i]) inq[i] = 8'($urandom);
            ref_run();
            tries++;
        end while (!m_halt && tries < 50);
        do_reset();
        got_out.delete();
        for (int c = 0; c < 4000 && !halted; c++) begin
            @(negedge clk);
            in_data   = inq[in_idx];
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && bus.in_ready) in_idx++;
            if (bus.out_valid && out_ready)
                got_out.push_back(bus.out_data);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_halted", halted, 1'b1);
        check("rnd_pc", bus.rom_addr, m_pc);
        for (int i = 0; i < 6; i++)
            check($sformatf("rnd_r%0d", i), dut.rf[i], m_r[i]);
        check("rnd_nin", 8'(in_idx), 8'(m_nin));
        check("rnd_nout", 8'(got_out.size()), 8'(exp_out.size()));
        n = got_out.size() < exp_out.size() ?
            got_out.size() : exp_out.size();
        for (int i = 0; i < n; i++)
            check("rnd_out", got_out[i], exp_out[i]);
    endtask

    initial begin
        logic [7:0] prog [11];
        logic [7:0] cv [3];
        prog = '{8'h05, 8'h81, 8'h0A, 8'h82, 8'h44, 8'h99,
                 8'h0F, 8'h82, 8'h45, 8'h00, 8'hC1};
        cv = '{8'h00, 8'h80, 8'h05};

        clear_rom();
        foreach (prog[i]) rom[i] = prog[i];
        #2;
        check("rst_pc", bus.rom_addr, 8'h00);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_halted", halted, 1'b0);
        do_reset();
        step(22);
        check("prog_r1", dut.rf[1], 8'd15);
        check("prog_r2", dut.rf[2], 8'd15);
        check("prog_r3", dut.rf[3], 8'd0);
        check("prog_r0", dut.rf[0], 8'd0);
        check("prog_pc", bus.rom_addr, 8'h00);
        check("prog_halted", halted, 1'b0);

        clear_rom();
        prog = '{8'hB1, 8'hB2, 8'h45, 8'h3F, 8'hB1, 8'hB2,
                 8'h44, 8'h46, 8'hBF, 8'h00, 8'h00};
        foreach (prog[i]) rom[i] = prog[i];
        do_reset();
        give(8'h80);
        give(8'h01);
        step(2);
        check("calc_sub", dut.rf[3], 8'h7F);
        step(2);
        check("imm_3f", dut.rf[0], 8'h3F);
        give(8'hFF);
        give(8'h02);
        step(2);
        check("calc_add", dut.rf[3], 8'h01);
        step(2);
        check("calc_nop", dut.rf[3], 8'h01);
        step(2);
        check("calc_halt", halted, 1'b1);

        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < 8; c++) begin
                clear_rom();
                rom[0] = 8'hB0;
                rom[1] = 8'hB3;
                rom[2] = 8'hC0 | 8'(c);
                do_reset();
                give(8'h40);
                give(cv[v]);
                step(2);
                check($sformatf("cond_%h_%0d", cv[v], c), bus.rom_addr,
                      cond_holds(3'(c), cv[v]) ? 8'h40 : 8'h03);
            end
        end

        clear_rom();
        rom[0] = 8'hB0;
        do_reset();
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("in_wait_ready", bus.in_ready, 1'b1);
            check("in_wait_pc", bus.rom_addr, 8'h00);
            step(1);
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step(1);
        in_valid = 1'b0;
        check("in_r0", dut.rf[0], 8'h5A);
        check("in_ready_drop", bus.in_ready, 1'b0);
        check("in_pc", bus.rom_addr, 8'h01);

        clear_rom();
        rom[0] = 8'h21;
        rom[1] = 8'h86;
        rom[2] = 8'hB6;
        rom[3] = 8'hBF;
        do_reset();
        step(4);
        for (int i = 0; i < 3; i++) begin
            check("out_hold_valid", bus.out_valid, 1'b1);
            check("out_hold_data", bus.out_data, 8'h21);
            check("out_hold_pc", bus.rom_addr, 8'h01);
            step(1);
        end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("out_done_valid", bus.out_valid, 1'b0);
        check("out_done_pc", bus.rom_addr, 8'h02);
        step(2);
        give(8'hC3);
        check("p2p_valid", bus.out_valid, 1'b1);
        check("p2p_data", bus.out_data, 8'hC3);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_out_data", bus.out_data, 8'h00);
        check("arst_pc", bus.rom_addr, 8'h00);
        check("arst_r0", dut.rf[0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        clear_rom();
        rom[0]   = 8'hB0;
        rom[1]   = 8'hC4;
        rom[255] = 8'h05;
        do_reset();
        give(8'hFF);
        step(2);
        check("wrap_jump", bus.rom_addr, 8'hFF);
        step(2);
        check("wrap_pc", bus.rom_addr, 8'h00);
        check("wrap_r0", dut.rf[0], 8'h05);

        clear_rom();
        rom[0] = 8'hBF;
        do_reset();
        step(2);
        check("halt_flag", halted, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step(5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("halt_stay", halted, 1'b1);
        check("halt_pc", bus.rom_addr, 8'h00);
        check("halt_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("halt_arst", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int p = 0; p < 12; p++) random_prog();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
